// File: rtl/cpu_defs.sv
// Shared instruction-format definitions for the 16-bit core.
// Used by the fetch, decode and hazard stages.
package cpu_defs;

  localparam int unsigned ISA_INSTR_W = 16;
  localparam int unsigned OPC_W       = 4;
  localparam int unsigned REG_ADDR_W  = 3;

  localparam logic [ISA_INSTR_W-1:0] NOP = 16'h0000;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RS_MSB  = 11;
  localparam int unsigned RS_LSB  = 9;
  localparam int unsigned RT_MSB  = 8;
  localparam int unsigned RT_LSB  = 6;
  localparam int unsigned RD_MSB  = 5;
  localparam int unsigned RD_LSB  = 3;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational-read imem.
interface fetch_stage_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc_i cycles, sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem and holds the IF/ID register.
// Redirect beats stall beats advance; debug counters track stalls and flushes.
module fetch_stage
  import cpu_defs::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [PC_W-1:0]       branch_target_i,
  fetch_stage_if.master         imem,
  output logic [INSTR_W-1:0]    if_id_instr_o,
  output logic [PC_W-1:0]       if_id_pc_o,
  output logic                  if_id_valid_o,
  output logic [OPC_W-1:0]      opcode_id_o,
  output logic [REG_ADDR_W-1:0] rs_id_o,
  output logic [REG_ADDR_W-1:0] rt_id_o,
  output logic [REG_ADDR_W-1:0] rd_id_o,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifpc_q, ifpc_d;
  logic               valid_q, valid_d;
  logic               stall_inc, flush_inc;

  // A stall that coincides with a redirect is not a held cycle.
  assign flush_inc = branch_taken_i;
  assign stall_inc = stall_i & ~branch_taken_i;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    if (branch_taken_i) begin
      pc_d    = branch_target_i;
      instr_d = INSTR_W'(NOP);
      ifpc_d  = '0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      pc_d    = pc_q + PC_W'(1);
      instr_d = imem.imem_rdata;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= PC_W'(RESET_PC);
      instr_q <= INSTR_W'(NOP);
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_inc),
    .count_o (stall_count_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush_inc),
    .count_o (flush_count_o)
  );

  assign imem.imem_addr = pc_q;
  assign if_id_instr_o  = instr_q;
  assign if_id_pc_o     = ifpc_q;
  assign if_id_valid_o  = valid_q;

  // Bubbles hold NOP, so decoded register fields read as zero.
  assign opcode_id_o = instr_q[OPC_MSB:OPC_LSB];
  assign rs_id_o     = instr_q[RS_MSB:RS_LSB];
  assign rt_id_o     = instr_q[RT_MSB:RT_LSB];
  assign rd_id_o     = instr_q[RD_MSB:RD_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns 16'h1000 | addr.
module tb_fetch_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [15:0] if_id_instr;
  logic [7:0]  if_id_pc;
  logic        if_id_valid;
  logic [3:0]  opcode_id;
  logic [2:0]  rs_id, rt_id, rd_id;
  logic [3:0]  stall_count, flush_count;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_stage_if #(.PC_W(8), .INSTR_W(16)) imem_bus ();

  assign imem_bus.imem_rdata = 16'h1000 | {8'h00, imem_bus.imem_addr};

  fetch_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(0), .CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .imem            (imem_bus),
    .if_id_instr_o   (if_id_instr),
    .if_id_pc_o      (if_id_pc),
    .if_id_valid_o   (if_id_valid),
    .opcode_id_o     (opcode_id),
    .rs_id_o         (rs_id),
    .rt_id_o         (rt_id),
    .rd_id_o         (rd_id),
    .stall_count_o   (stall_count),
    .flush_count_o   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  32'(imem_bus.imem_addr), 32'h0);
    chk({tag, "_instr"}, 32'(if_id_instr), 32'h0);
    chk({tag, "_ifpc"},  32'(if_id_pc), 32'h0);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    chk({tag, "_scnt"},  32'(stall_count), 32'h0);
    chk({tag, "_fcnt"},  32'(flush_count), 32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    step(); step();
    chk_reset("reset");
    chk("reset_rd", 32'(rd_id), 32'h0);

    // Free run: first rst-low edge latches the word at RESET_PC.
    rst = 1'b0;
    step();
    chk("run1_valid", 32'(if_id_valid), 32'h1);
    chk("run1_ifpc",  32'(if_id_pc), 32'h0);
    chk("run1_instr", 32'(if_id_instr), 32'h1000);
    chk("run1_addr",  32'(imem_bus.imem_addr), 32'h1);
    step();
    chk("run2_ifpc",  32'(if_id_pc), 32'h1);
    chk("run2_instr", 32'(if_id_instr), 32'h1001);
    chk("run2_addr",  32'(imem_bus.imem_addr), 32'h2);
    step(); step(); step();
    chk("pre_stall_addr", 32'(imem_bus.imem_addr), 32'h5);
    chk("pre_stall_ifpc", 32'(if_id_pc), 32'h4);

    // Three-cycle stall.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", 32'(imem_bus.imem_addr), 32'h5);
      chk("stall_ifpc", 32'(if_id_pc), 32'h4);
    end
    chk("stall_cnt3", 32'(stall_count), 32'h3);
    stall = 1'b0;
    step();
    chk("release_ifpc",  32'(if_id_pc), 32'h5);
    chk("release_instr", 32'(if_id_instr), 32'h1005);
    chk("release_addr",  32'(imem_bus.imem_addr), 32'h6);
    step(); step(); step(); step();
    chk("pre_br_addr", 32'(imem_bus.imem_addr), 32'hA);

    // Redirect to 0x40.
    branch_taken = 1'b1; branch_target = 8'h40;
    step();
    branch_taken = 1'b0;
    chk("br_addr",  32'(imem_bus.imem_addr), 32'h40);
    chk("br_valid", 32'(if_id_valid), 32'h0);
    chk("br_instr", 32'(if_id_instr), 32'h0);
    chk("br_ifpc",  32'(if_id_pc), 32'h0);
    chk("br_rsrtrd", 32'({rs_id, rt_id, rd_id}), 32'h0);
    chk("br_fcnt",  32'(flush_count), 32'h1);
    step();
    chk("br2_ifpc",  32'(if_id_pc), 32'h40);
    chk("br2_valid", 32'(if_id_valid), 32'h1);
    chk("br2_instr", 32'(if_id_instr), 32'h1040);
    chk("br2_rt",    32'(rt_id), 32'h1);

    // Stall and redirect together: redirect wins, no stall counted.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h20;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    chk("both_addr",  32'(imem_bus.imem_addr), 32'h20);
    chk("both_valid", 32'(if_id_valid), 32'h0);
    chk("both_scnt",  32'(stall_count), 32'h3);
    chk("both_fcnt",  32'(flush_count), 32'h2);
    step();
    chk("both2_ifpc", 32'(if_id_pc), 32'h20);

    // PC wrap from 0xFF.
    branch_taken = 1'b1; branch_target = 8'hFF;
    step();
    branch_taken = 1'b0;
    chk("wrap_pre_addr", 32'(imem_bus.imem_addr), 32'hFF);
    step();
    chk("wrap_addr",  32'(imem_bus.imem_addr), 32'h0);
    chk("wrap_ifpc",  32'(if_id_pc), 32'hFF);
    chk("wrap_instr", 32'(if_id_instr), 32'h10FF);
    chk("wrap_dec",   32'({opcode_id, rs_id, rt_id, rd_id}), 32'({4'h1, 3'd0, 3'd3, 3'd7}));

    // Reset during a stall.
    stall = 1'b1;
    step();
    chk("mid_stall_scnt", 32'(stall_count), 32'h4);
    rst = 1'b1;
    step();
    chk_reset("rst_stall");
    rst = 1'b0; stall = 1'b0;
    step(); step();

    // Reset during a redirect.
    rst = 1'b1; branch_taken = 1'b1; branch_target = 8'h77;
    step();
    chk_reset("rst_br");
    rst = 1'b0; branch_taken = 1'b0;

    // Long stall saturates the 4-bit counter.
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_scnt", 32'(stall_count), 32'hF);
    step();
    chk("sat_scnt_hold", 32'(stall_count), 32'hF);
    chk("sat_addr", 32'(imem_bus.imem_addr), 32'h0);
    stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
